bcd_scan_decoder: RTL and testbench
===================================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, legal range 1..16: number of packed BCD digits per input word.
REQ-002 SHALL have localparam IDXW = max(1, clog2(DIGITS)): width of the digit index.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port in_valid  input  1  in_data holds a word to decode.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  4*DIGITS  packed BCD word, digit 0 in bits [3:0].
REQ-008 SHALL have port out_valid  output  1  out_* fields hold a decoded digit.
REQ-009 SHALL have port out_ready  input  1  consumer takes the current digit.
REQ-010 SHALL have port out_onehot  output  10  one-hot decode: bit n set for digit value n (0..9).
REQ-011 SHALL have port out_idx  output  IDXW  position of the current digit in the word.
REQ-012 SHALL have port out_last  output  1  current digit is digit DIGITS-1.
REQ-013 SHALL have port out_err  output  1  current digit code is 4'hA..4'hF.
REQ-014 SHALL have port err_seen  output  1  sticky: some digit of the current/last word was invalid.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-016 SHALL drive in_ready = 1 in IDLE and 0 in SCAN; no overlap between words.
REQ-017 IDLE->SCAN SHALL occur on the edge where in_valid && in_ready; that edge captures in_data, loads digit 0 decode into the output registers, sets out_valid=1, out_idx=0, and clears err_seen.
REQ-018 Output fields SHALL be registered; first digit is visible in the cycle after acceptance (latency 1).
REQ-019 While out_valid && !out_ready, out_onehot, out_idx, out_last and out_err SHALL stay stable.
REQ-020 On out_valid && out_ready with out_last=0, the next edge SHALL load digit out_idx+1; one digit per accepted cycle.
REQ-021 On out_valid && out_ready with out_last=1, the next edge SHALL set out_valid=0 and return to IDLE.
REQ-022 For codes 4'hA..4'hF: out_onehot=10'b0, out_err=1; err_seen SHALL be set on the edge that loads such a digit and hold until the next acceptance or reset.
REQ-023 For DIGITS=1, out_last SHALL be 1 and out_idx 0 for the sole digit.
REQ-024 in_valid while in SCAN SHALL be ignored; the source holds the word until in_ready.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, out_valid=0, out_onehot=0, out_idx=0, out_last=0, out_err=0, err_seen=0, captured word=0.
REQ-026 Reset during SCAN SHALL discard the in-flight word; in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-027 Macro BCD_SCAN_DECODER_XS3_EN, when defined, SHALL add output port out_xs3 (output, 4): excess-3 code of the current digit (value+3), registered with out_onehot; 4'h0 for invalid codes and at reset.
REQ-028 Without BCD_SCAN_DECODER_XS3_EN, out_xs3 and its logic SHALL be absent; all other behaviour identical.

Verification (DIGITS=4)
REQ-029 in_data=16'h1293, out_ready=1 -> onehot 10'h008,10'h200,10'h004,10'h002 on idx 0..3, out_last only at idx 3, out_err=0, in_ready back to 1 after last handshake.
REQ-030 in_data=16'h00A5 -> idx0 onehot 10'h020; idx1 onehot 0, out_err=1, err_seen=1 from that cycle through idx 3; next accepted word clears err_seen.
REQ-031 out_ready low 3 cycles on idx 2 of 16'h4321 -> out_onehot=10'h008, out_idx=2 held stable; resumes with idx 3 onehot 10'h010.
REQ-032 rst_n pulsed low during idx 1 of 16'h9876 -> all outputs zero immediately, in_ready=1 after release, next word 16'h0000 decodes to 10'h001 x4.
REQ-033 in_valid held high in SCAN with different data -> ignored until IDLE; then accepted once.
REQ-034 With BCD_SCAN_DECODER_XS3_EN, 16'h9093 -> out_xs3 = 4'h6,4'hC,4'h3,4'hC.

Source files
------------

// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder: accepts a packed BCD word and presents its digits one per
// accepted output cycle as a one-hot decode with index, last and error flags.
// Optional feature: define BCD_SCAN_DECODER_XS3_EN to add the out_xs3 port
// (excess-3 code of the current digit, registered with out_onehot).
module bcd_scan_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9:0]            out_onehot,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  err_seen
`ifdef BCD_SCAN_DECODER_XS3_EN
  ,
  output logic [3:0]            out_xs3
`endif
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [4*DIGITS-1:0] word_p0;
  logic [4*DIGITS-1:0] src_word;
  logic                vld_p1;
  logic [9:0]          onehot_p1;
  logic [IDXW-1:0]     idx_p1;
  logic                last_p1;
  logic                err_p1;
  logic                seen_p1;
`ifdef BCD_SCAN_DECODER_XS3_EN
  logic [3:0]          xs3_p1;
`endif

  logic                accept;
  logic                adv;
  logic                done;
  logic [IDXW-1:0]     sel_idx;
  logic [3:0]          sel_dig;

  function automatic logic bcd_invalid(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  function automatic logic [9:0] bcd_onehot(input logic [3:0] d);
    logic [9:0] oh;
    oh = '0;
    if (!bcd_invalid(d)) oh = 10'b1 << d;
    return oh;
  endfunction

  function automatic logic [3:0] bcd_xs3(input logic [3:0] d);
    logic [3:0] x;
    x = 4'h0;
    if (!bcd_invalid(d)) x = d + 4'd3;
    return x;
  endfunction

  assign accept = in_valid && in_ready;
  assign adv    = vld_p1 && out_ready && !last_p1;
  assign done   = vld_p1 && out_ready && last_p1;

  // State register; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and input handshake: one word at a time, no overlap.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the digit to load next: digit 0 of the incoming word on acceptance,
  // otherwise the digit after the one currently presented.
  always_comb begin
    src_word = accept ? in_data : word_p0;
    sel_idx  = accept ? '0 : (idx_p1 + IDXW'(1));
    sel_dig  = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_idx == IDXW'(i)) sel_dig = src_word[4*i +: 4];
    end
  end

  // ---- stage p0: captured word ----
  // Hold the accepted word for the whole scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      word_p0 <= '0;
    else if (accept) word_p0 <= in_data;
  end

  // ---- stage p1: presented digit ----
  // Output valid and the sticky error flag, which restarts with each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      seen_p1 <= 1'b0;
    end else begin
      if (accept)    vld_p1 <= 1'b1;
      else if (done) vld_p1 <= 1'b0;
      if (accept)    seen_p1 <= bcd_invalid(sel_dig);
      else if (adv)  seen_p1 <= seen_p1 | bcd_invalid(sel_dig);
    end
  end

  // Decoded fields change only when a new digit is loaded, so they hold
  // steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_p1 <= '0;
      idx_p1    <= '0;
      last_p1   <= 1'b0;
      err_p1    <= 1'b0;
`ifdef BCD_SCAN_DECODER_XS3_EN
      xs3_p1    <= 4'h0;
`endif
    end else if (accept || adv) begin
      onehot_p1 <= bcd_onehot(sel_dig);
      idx_p1    <= sel_idx;
      last_p1   <= (sel_idx == LAST_IDX);
      err_p1    <= bcd_invalid(sel_dig);
`ifdef BCD_SCAN_DECODER_XS3_EN
      xs3_p1    <= bcd_xs3(sel_dig);
`endif
    end
  end

  assign out_valid  = vld_p1;
  assign out_onehot = onehot_p1;
  assign out_idx    = idx_p1;
  assign out_last   = last_p1;
  assign out_err    = err_p1;
  assign err_seen   = seen_p1;
`ifdef BCD_SCAN_DECODER_XS3_EN
  assign out_xs3    = xs3_p1;
`endif

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Scoreboard bench for bcd_scan_decoder (DIGITS=4). Expected digits are
// queued when a word is issued; a monitor pops one entry per output handshake.
module tb_bcd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_onehot;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_err;
  logic        err_seen;
`ifdef BCD_SCAN_DECODER_XS3_EN
  logic [3:0]  out_xs3;
`endif

  typedef struct packed {
    logic [9:0] oh;
    logic [1:0] idx;
    logic       last;
    logic       err;
    logic       seen;
    logic [3:0] xs3;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  bcd_scan_decoder #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_err    (out_err),
    .err_seen   (err_seen)
`ifdef BCD_SCAN_DECODER_XS3_EN
    ,
    .out_xs3    (out_xs3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push(input logic [9:0] oh, input logic [1:0] idx, input logic last,
                      input logic err, input logic seen, input logic [3:0] xs3);
    exp_t e;
    e = '{oh: oh, idx: idx, last: last, err: err, seen: seen, xs3: xs3};
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) fail_timeout("accept");
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [1:0] k);
    int t;
    t = 0;
    while (!(out_valid && out_idx == k) && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) fail_timeout("wait_idx");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((out_valid || q.size() != 0) && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) fail_timeout("drain");
  endtask

  // Monitor: one expected entry per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_digit: got idx %0d onehot %0h, expected none", out_idx, out_onehot);
      end else begin
        mon_e = q.pop_front();
        chk("onehot",   32'(out_onehot), 32'(mon_e.oh));
        chk("idx",      32'(out_idx),    32'(mon_e.idx));
        chk("last",     32'(out_last),   32'(mon_e.last));
        chk("err",      32'(out_err),    32'(mon_e.err));
        chk("err_seen", 32'(err_seen),   32'(mon_e.seen));
`ifdef BCD_SCAN_DECODER_XS3_EN
        chk("xs3",      32'(out_xs3),    32'(mon_e.xs3));
`endif
      end
    end
  end

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_onehot",    32'(out_onehot), 32'd0);
    chk("rst_idx",       32'(out_idx),    32'd0);
    chk("rst_last",      32'(out_last),   32'd0);
    chk("rst_err",       32'(out_err),    32'd0);
    chk("rst_err_seen",  32'(err_seen),   32'd0);
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // Plain word, consumer always ready.
    push(10'h008, 2'd0, 1'b0, 1'b0, 1'b0, 4'h6);
    push(10'h200, 2'd1, 1'b0, 1'b0, 1'b0, 4'hC);
    push(10'h004, 2'd2, 1'b0, 1'b0, 1'b0, 4'h5);
    push(10'h002, 2'd3, 1'b1, 1'b0, 1'b0, 4'h4);
    send(16'h1293);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    drain();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Invalid digit in position 1 makes err_seen sticky for the rest.
    push(10'h020, 2'd0, 1'b0, 1'b0, 1'b0, 4'h8);
    push(10'h000, 2'd1, 1'b0, 1'b1, 1'b1, 4'h0);
    push(10'h001, 2'd2, 1'b0, 1'b0, 1'b1, 4'h3);
    push(10'h001, 2'd3, 1'b1, 1'b0, 1'b1, 4'h3);
    send(16'h00A5);
    drain();
    chk("seen_held_idle", 32'(err_seen), 32'd1);

    // Next word clears err_seen; stall three cycles on digit 2.
    push(10'h002, 2'd0, 1'b0, 1'b0, 1'b0, 4'h4);
    push(10'h004, 2'd1, 1'b0, 1'b0, 1'b0, 4'h5);
    push(10'h008, 2'd2, 1'b0, 1'b0, 1'b0, 4'h6);
    push(10'h010, 2'd3, 1'b1, 1'b0, 1'b0, 4'h7);
    send(16'h4321);
    wait_idx(2'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid",  32'(out_valid),  32'd1);
      chk("stall_onehot", 32'(out_onehot), 32'h008);
      chk("stall_idx",    32'(out_idx),    32'd2);
    end
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while digit 1 is presented.
    push(10'h040, 2'd0, 1'b0, 1'b0, 1'b0, 4'h9);
    send(16'h9876);
    wait_idx(2'd1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid),  32'd0);
    chk("arst_onehot",    32'(out_onehot), 32'd0);
    chk("arst_idx",       32'(out_idx),    32'd0);
    chk("arst_err_seen",  32'(err_seen),   32'd0);
    chk("arst_in_ready",  32'(in_ready),   32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(in_ready),  32'd1);
    chk("post_rst_valid",    32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push(10'h001, 2'd0, 1'b0, 1'b0, 1'b0, 4'h3);
    push(10'h001, 2'd1, 1'b0, 1'b0, 1'b0, 4'h3);
    push(10'h001, 2'd2, 1'b0, 1'b0, 1'b0, 4'h3);
    push(10'h001, 2'd3, 1'b1, 1'b0, 1'b0, 4'h3);
    send(16'h0000);
    drain();

    // in_valid held through SCAN with new data: second word taken only once.
    push(10'h080, 2'd0, 1'b0, 1'b0, 1'b0, 4'hA);
    push(10'h002, 2'd1, 1'b0, 1'b0, 1'b0, 4'h4);
    push(10'h100, 2'd2, 1'b0, 1'b0, 1'b0, 4'hB);
    push(10'h001, 2'd3, 1'b1, 1'b0, 1'b0, 4'h3);
    push(10'h010, 2'd0, 1'b0, 1'b0, 1'b0, 4'h7);
    push(10'h040, 2'd1, 1'b0, 1'b0, 1'b0, 4'h9);
    push(10'h004, 2'd2, 1'b0, 1'b0, 1'b0, 4'h5);
    push(10'h008, 2'd3, 1'b1, 1'b0, 1'b0, 4'h6);
    send(16'h0817);
    in_data  = 16'h3264;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) fail_timeout("second_accept");
    step();
    in_valid = 1'b0;
    drain();
    step();
    step();
    chk("single_accept_idle", 32'(out_valid), 32'd0);

`ifdef BCD_SCAN_DECODER_XS3_EN
    push(10'h008, 2'd0, 1'b0, 1'b0, 1'b0, 4'h6);
    push(10'h200, 2'd1, 1'b0, 1'b0, 1'b0, 4'hC);
    push(10'h001, 2'd2, 1'b0, 1'b0, 1'b0, 4'h3);
    push(10'h200, 2'd3, 1'b1, 1'b0, 1'b0, 4'hC);
    send(16'h9093);
    drain();
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
